// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the restoring divider.
// Optional signed mode is enabled by defining DIVIDER_SIGNED_EN.
package divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    // Counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Carry-lookahead subtractor: diff = a + ~b + 1, borrow_n is the carry out
// (1 means a >= b, no borrow).
module cla_subtractor #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_n
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    // Each carry is a flat sum of generate terms gated by propagate runs.
    always_comb begin
        logic acc;
        logic run;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            acc = gen[i];
            run = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (run & gen[j]);
                run = run & prop[j];
            end
            carry[i+1] = acc | run;
        end
    end

    assign diff     = prop ^ carry[WIDTH-1:0];
    assign borrow_n = carry[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's complement operands (truncating division).
module restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
`ifdef DIVIDER_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             unused_trial_msb;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};

    cla_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a        (shifted),
        .b        ({1'b0, dvs_q}),
        .diff     (trial),
        .borrow_n (no_borrow)
    );

    // A kept difference is always below the divisor, so its top bit is zero.
    assign unused_trial_msb = trial[WIDTH];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d = '0;
                    cnt_d = CntW'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
                    dvd_d  = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_d  = divisor[WIDTH-1] ? -divisor : divisor;
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
`else
                    dvd_d = dividend;
                    dvs_d = divisor;
`endif
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
`ifdef DIVIDER_SIGNED_EN
                    quot_d = qneg_q ? -dvd_d : dvd_d;
                    rmd_d  = rneg_q ? -rem_d : rem_d;
`else
                    quot_d = dvd_d;
                    rmd_d  = rem_d;
`endif
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: scoreboard of expected results,
// one task per scenario, cycle-accurate busy/done timing checks.
module tb_restoring_divider;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } result_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int      n_checks = 0;
    int      n_fail   = 0;
    result_t sb[$];
    result_t exp_r;
    int      cyc;

    restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        result_t res;
        if (b == '0) begin
            res.q   = '1;
            res.r   = a;
            res.dbz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            int sa;
            int sb_v;
            sa    = $signed(a);
            sb_v  = $signed(b);
            res.q = W'(sa / sb_v);
            res.r = W'(sa % sb_v);
`else
            res.q = a / b;
            res.r = a % b;
`endif
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    function automatic result_t pop_exp();
        result_t res;
        res = 'x;
        if (sb.size() > 0) res = sb.pop_front();
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
    endtask

    // Drive start for the acceptance cycle, then scramble operands.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        push_start(a, b);
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Returns the cycle (1 = cycle after acceptance) in which done is seen, -1 on timeout.
    task automatic wait_done(output int c);
        c = -1;
        for (int k = 1; k <= int'(3 * W); k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                c = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset busy/done: got %b want 00", {busy, done});
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got q=%b r=%b dbz=%b want zeros",
                     quotient, remainder, div_by_zero);
        end
        rst = 1'b0; start = 1'b0;
        step();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset idle: got busy=%b want 0", busy);
        end
        step();
    endtask

    task automatic test_basic();
        issue(4'd13, 4'd3);
        exp_r = pop_exp();
        for (int k = 1; k <= int'(W + 1); k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done} !== {1'b1, k == int'(W + 1)}) begin
                n_fail++;
                $display("FAIL basic timing cycle %0d: got busy/done=%b%b want 1%b",
                         k, busy, done, k == int'(W + 1));
            end
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL basic result: got q=%b r=%b dbz=%b want q=%b r=%b dbz=%b",
                     quotient, remainder, div_by_zero, exp_r.q, exp_r.r, exp_r.dbz);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== {2'b00, exp_r}) begin
            n_fail++;
            $display("FAIL basic hold: got busy=%b done=%b q=%b r=%b want 0 0 q=%b r=%b",
                     busy, done, quotient, remainder, exp_r.q, exp_r.r);
        end
        step();
    endtask

    task automatic test_back_to_back();
        issue(4'd15, 4'd1);
        wait_done(cyc);
        exp_r = pop_exp();
        n_checks++;
        if (cyc !== int'(W + 1)) begin
            n_fail++; $display("FAIL b2b first latency: got %0d want %0d", cyc, W + 1);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL b2b first result: got q=%b r=%b want q=%b r=%b",
                     quotient, remainder, exp_r.q, exp_r.r);
        end
        step();
        issue(4'd3, 4'd7);
        wait_done(cyc);
        exp_r = pop_exp();
        n_checks++;
        if (cyc !== int'(W + 1)) begin
            n_fail++; $display("FAIL b2b second latency: got %0d want %0d", cyc, W + 1);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL b2b second result: got q=%b r=%b want q=%b r=%b",
                     quotient, remainder, exp_r.q, exp_r.r);
        end
        step();
    endtask

    task automatic test_div_by_zero();
        issue(4'd5, 4'd0);
        exp_r = pop_exp();
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b11) begin
            n_fail++; $display("FAIL dbz timing: got busy/done=%b%b want 11", busy, done);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL dbz result: got q=%b r=%b dbz=%b want q=%b r=%b dbz=%b",
                     quotient, remainder, div_by_zero, exp_r.q, exp_r.r, exp_r.dbz);
        end
        step();
        push_start(4'd9, 4'd2);
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL dbz idle at cycle 2: got busy/done=%b%b want 00", busy, done);
        end
        step();
        start = 1'b0;
        wait_done(cyc);
        exp_r = pop_exp();
        n_checks++;
        if (cyc !== int'(W + 1)) begin
            n_fail++; $display("FAIL dbz follow-up latency: got %0d want %0d", cyc, W + 1);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL dbz follow-up result: got q=%b r=%b dbz=%b want q=%b r=%b dbz=%b",
                     quotient, remainder, div_by_zero, exp_r.q, exp_r.r, exp_r.dbz);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int extra_done;
        issue(4'd12, 4'd5);
        step();
        dividend = 4'd1; divisor = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL ignore done at cycle 5: got %b want 1", done);
        end
        exp_r = pop_exp();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL ignore result: got q=%b r=%b want q=%b r=%b",
                     quotient, remainder, exp_r.q, exp_r.r);
        end
        step();
        start = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        n_checks++;
        if (extra_done !== 0) begin
            n_fail++; $display("FAIL ignore extra activity: got %0d busy/done cycles want 0", extra_done);
        end
        step();
    endtask

    task automatic test_reset_abort();
        issue(4'd14, 4'd3);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        push_start(4'd6, 4'd2);
        @(negedge clk);
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL abort outputs: got busy=%b done=%b q=%b r=%b dbz=%b want zeros",
                     busy, done, quotient, remainder, div_by_zero);
        end
        step();
        start = 1'b0;
        wait_done(cyc);
        exp_r = pop_exp();
        n_checks++;
        if (cyc !== int'(W + 1)) begin
            n_fail++; $display("FAIL abort restart latency: got %0d want %0d", cyc, W + 1);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp_r) begin
            n_fail++;
            $display("FAIL abort restart result: got q=%b r=%b want q=%b r=%b",
                     quotient, remainder, exp_r.q, exp_r.r);
        end
        step();
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int n = 0; n < 24; n++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            issue(a, b);
            wait_done(cyc);
            exp_r = pop_exp();
            n_checks++;
            if (cyc !== ((b == '0) ? 1 : int'(W + 1))) begin
                n_fail++; $display("FAIL random latency %0d/%0d: got %0d", a, b, cyc);
            end
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== exp_r) begin
                n_fail++;
                $display("FAIL random %b/%b: got q=%b r=%b dbz=%b want q=%b r=%b dbz=%b",
                         a, b, quotient, remainder, div_by_zero, exp_r.q, exp_r.r, exp_r.dbz);
            end
            step();
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        issue(4'b1001, 4'b0010);
        wait_done(cyc);
        exp_r = pop_exp();
        n_checks++;
        if ({quotient, remainder} !== {4'b1101, 4'b1111}) begin
            n_fail++; $display("FAIL signed -7/2: got q=%b r=%b want q=1101 r=1111", quotient, remainder);
        end
        step();
        issue(4'b1000, 4'b1111);
        wait_done(cyc);
        exp_r = pop_exp();
        n_checks++;
        if ({quotient, remainder} !== {4'b1000, 4'b0000}) begin
            n_fail++; $display("FAIL signed -8/-1: got q=%b r=%b want q=1000 r=0000", quotient, remainder);
        end
        step();
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_ignore_start();
        test_reset_abort();
        test_random();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
